// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX control wrapper.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_IDLE = 2'd1,
    APPLY     = 2'd2,
    SETTLE    = 2'd3
  } ctrl_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic [5:0] PRESCALE_RST = PRESCALE_8;
  localparam logic       PAR_EN_RST   = 1'b1;
  localparam logic       PAR_TYP_RST  = 1'b0;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; registered level, combinational head read.
// Push on a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign drop     = push && full && !pop_ok;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control wrapper: frame-safe config updates, received-byte FIFO,
// saturating parity/stop error counters and a sticky overrun flag.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cfg_wr,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  rx_busy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  output logic                  rx_enable,
  output logic [5:0]            Prescale,
  output logic                  PAR_EN,
  output logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
  input  logic                  err_clr
);

  ctrl_state_t state, state_nxt;

  logic [5:0] sh_prescale;
  logic       sh_par_en;
  logic       sh_par_typ;
  logic       cfg_accept;
  logic       cfg_reject;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;

  assign cfg_accept = (state == RUN) && cfg_wr && prescale_legal(cfg_prescale);
  assign cfg_reject = (state == RUN) && cfg_wr && !prescale_legal(cfg_prescale);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (cfg_accept) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!rx_busy)   state_nxt = APPLY;
      APPLY:     state_nxt = SETTLE;
      SETTLE:    state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // While waiting, enable simply follows rx_busy so an idle core cannot start a new frame.
  always_comb begin
    rx_enable = 1'b1;
    cfg_busy  = 1'b0;
    case (state)
      RUN:       begin rx_enable = 1'b1;    cfg_busy = 1'b0; end
      WAIT_IDLE: begin rx_enable = rx_busy; cfg_busy = 1'b1; end
      APPLY:     begin rx_enable = 1'b0;    cfg_busy = 1'b1; end
      SETTLE:    begin rx_enable = 1'b0;    cfg_busy = 1'b1; end
      default:   begin rx_enable = 1'b0;    cfg_busy = 1'b1; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_prescale <= PRESCALE_RST;
      sh_par_en   <= PAR_EN_RST;
      sh_par_typ  <= PAR_TYP_RST;
      Prescale    <= PRESCALE_RST;
      PAR_EN      <= PAR_EN_RST;
      PAR_TYP     <= PAR_TYP_RST;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_reject;
      if (cfg_accept) begin
        sh_prescale <= cfg_prescale;
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
      end
      if (state == APPLY) begin
        Prescale <= sh_prescale;
        PAR_EN   <= sh_par_en;
        PAR_TYP  <= sh_par_typ;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (rx_data_valid),
    .push_data (rx_data),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign out_valid = !fifo_empty;

  // err_clr takes priority over any same-cycle increment or drop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      overrun     <= 1'b0;
    end else if (err_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      overrun     <= 1'b0;
    end else begin
      if (rx_par_err && (par_err_cnt != '1)) par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
      if (rx_stp_err && (stp_err_cnt != '1)) stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
      if (fifo_drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: reset, reconfiguration, FIFO and error counters.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic       cfg_busy;
  logic       cfg_err;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic       rx_enable;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_level;
  logic       overrun;
  logic [7:0] par_err_cnt;
  logic [7:0] stp_err_cnt;
  logic       err_clr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .cfg_wr        (cfg_wr),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .rx_busy       (rx_busy),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .rx_enable     (rx_enable),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .par_err_cnt   (par_err_cnt),
    .stp_err_cnt   (stp_err_cnt),
    .err_clr       (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data       = d;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  logic [7:0] exp_q [4];

  initial begin
    RST = 1'b0;
    cfg_wr = 1'b0; cfg_prescale = 6'd8; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
    rx_busy = 1'b0; rx_data = '0; rx_data_valid = 1'b0;
    rx_par_err = 1'b0; rx_stp_err = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;

    // reset state
    chk("rst_prescale", 32'(Prescale), 32'd8);
    chk("rst_par_en",   32'(PAR_EN), 32'd1);
    chk("rst_par_typ",  32'(PAR_TYP), 32'd0);
    chk("rst_rx_en",    32'(rx_enable), 32'd1);
    chk("rst_out_vld",  32'(out_valid), 32'd0);
    chk("rst_out_dat",  32'(out_data), 32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_par_cnt",  32'(par_err_cnt), 32'd0);
    chk("rst_stp_cnt",  32'(stp_err_cnt), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_overrun",  32'(overrun), 32'd0);

    // reconfigure to 16 / no parity / odd while a frame is in progress
    rx_busy = 1'b1;
    cfg_prescale = 6'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    #1;
    chk("wait_busy",   32'(cfg_busy), 32'd1);
    chk("wait_rx_en",  32'(rx_enable), 32'd1);
    chk("wait_presc",  32'(Prescale), 32'd8);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        cfg_wr = 1'b1; cfg_prescale = 6'd32;
      end
      tick();
      cfg_wr = 1'b0;
    end
    chk("mid_presc",   32'(Prescale), 32'd8);
    chk("mid_busy",    32'(cfg_busy), 32'd1);
    rx_busy = 1'b0;
    #1;
    chk("idle_rx_en",  32'(rx_enable), 32'd0);
    tick();
    chk("apply_rx_en", 32'(rx_enable), 32'd0);
    chk("apply_presc", 32'(Prescale), 32'd8);
    chk("apply_busy",  32'(cfg_busy), 32'd1);
    tick();
    chk("settle_presc",  32'(Prescale), 32'd16);
    chk("settle_par_en", 32'(PAR_EN), 32'd0);
    chk("settle_par_typ",32'(PAR_TYP), 32'd1);
    chk("settle_rx_en",  32'(rx_enable), 32'd0);
    chk("settle_busy",   32'(cfg_busy), 32'd1);
    tick();
    chk("run_busy",    32'(cfg_busy), 32'd0);
    chk("run_rx_en",   32'(rx_enable), 32'd1);
    chk("run_presc",   32'(Prescale), 32'd16);

    // illegal prescale
    chk("pre_cfg_err", 32'(cfg_err), 32'd0);
    cfg_prescale = 6'd12; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    #1;
    chk("bad_cfg_err", 32'(cfg_err), 32'd1);
    chk("bad_busy",    32'(cfg_busy), 32'd0);
    chk("bad_presc",   32'(Prescale), 32'd16);
    tick();
    chk("bad_err_end", 32'(cfg_err), 32'd0);
    chk("bad_rx_en",   32'(rx_enable), 32'd1);

    // fill past depth with consumer stalled
    push(8'hA5);
    chk("first_vld",  32'(out_valid), 32'd1);
    chk("first_dat",  32'(out_data), 32'hA5);
    push(8'h3C); push(8'hFF); push(8'h01);
    chk("full_ovr0",  32'(overrun), 32'd0);
    push(8'h77);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ovr",   32'(overrun), 32'd1);
    chk("stall_dat",  32'(out_data), 32'hA5);
    exp_q[0] = 8'hA5; exp_q[1] = 8'h3C; exp_q[2] = 8'hFF; exp_q[3] = 8'h01;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pop%0d", i), 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_vld",   32'(out_valid), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // simultaneous push and pop on a full FIFO
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("pp_full", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    push(8'h55);
    out_ready = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_ovr",   32'(overrun), 32'd0);
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pp_pop%0d", i), 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("pp_empty", 32'(out_valid), 32'd0);

    // error counters
    rx_stp_err = 1'b1;
    repeat (3) tick();
    rx_stp_err = 1'b0;
    chk("stp_cnt3", 32'(stp_err_cnt), 32'd3);
    rx_par_err = 1'b1;
    repeat (260) tick();
    rx_par_err = 1'b0;
    chk("par_sat", 32'(par_err_cnt), 32'd255);
    chk("stp_hold", 32'(stp_err_cnt), 32'd3);
    err_clr = 1'b1; rx_stp_err = 1'b1;
    tick();
    err_clr = 1'b0; rx_stp_err = 1'b0;
    chk("clr_par", 32'(par_err_cnt), 32'd0);
    chk("clr_stp", 32'(stp_err_cnt), 32'd0);

    // async reset in the middle of a reconfiguration
    rx_busy = 1'b1;
    cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    rx_par_err = 1'b1;
    push(8'h9C);
    rx_par_err = 1'b0;
    chk("ar_busy_pre", 32'(cfg_busy), 32'd1);
    chk("ar_vld_pre",  32'(out_valid), 32'd1);
    #1 RST = 1'b0;
    #1;
    chk("ar_busy",  32'(cfg_busy), 32'd0);
    chk("ar_presc", 32'(Prescale), 32'd8);
    chk("ar_paren", 32'(PAR_EN), 32'd1);
    chk("ar_vld",   32'(out_valid), 32'd0);
    chk("ar_par",   32'(par_err_cnt), 32'd0);
    rx_busy = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    tick();
    chk("ar_rx_en", 32'(rx_enable), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
